// File: rtl/jump_button_ctrl.sv
// Jump push-button controller: sync + press/release debounce, hold-duration timer,
// sticky edge capture with maskable level IRQ, exposed as a 4-word Avalon-MM slave.
module jump_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int HOLD_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  state_t             state;
  logic               s1, s2;
  logic [CNT_W-1:0]   dcnt;
  logic               level;
  logic [1:0]         edgecap;
  logic [1:0]         irqmask;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_last;
  logic               press_acc, rel_acc;
  logic [1:0]         w1c;
  logic               unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Accept events are decoded from current state so edgecap can merge set and W1C
  assign press_acc = (state == PRESS_DB)   &&  s2 && (dcnt == DB_LAST);
  assign rel_acc   = (state == RELEASE_DB) && !s2 && (dcnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= '0;
      level     <= 1'b0;
      hold_cnt  <= '0;
      hold_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_DB;
            dcnt  <= '0;
          end
        end
        PRESS_DB: begin
          if (!s2) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
            if (dcnt == DB_LAST) begin
              state    <= HELD;
              level    <= 1'b1;
              hold_cnt <= '0;
            end
          end
        end
        HELD: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (!s2) begin
            state <= RELEASE_DB;
            dcnt  <= '0;
          end
        end
        RELEASE_DB: begin
          // Duration keeps running through release debounce and bounces
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (s2) begin
            state <= HELD;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
            if (dcnt == DB_LAST) begin
              state     <= IDLE;
              level     <= 1'b0;
              hold_last <= hold_cnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign w1c = (chipselect && write && address == 2'd2) ? writedata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      edgecap <= 2'b00;
      irqmask <= 2'b00;
    end else begin
      if (chipselect && write && address == 2'd1) irqmask <= writedata[1:0];
      edgecap <= (edgecap & ~w1c) | {rel_acc, press_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {30'b0, s2, level};
        2'd1:    readdata <= {30'b0, irqmask};
        2'd2:    readdata <= {30'b0, edgecap};
        default: readdata <= 32'(hold_last);
      endcase
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_jump_button_ctrl.sv
// Scoreboard bench for jump_button_ctrl: two instances (HOLD_W 32 and 8) share stimulus;
// reads push expected values, a negedge monitor pops and compares readdata/irq.
module tb_jump_button_ctrl;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset, in_port, chipselect, write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] rd32, rd8;
  logic        irq32, irq8;

  always #5 clk = ~clk;

  jump_button_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16), .HOLD_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .readdata(rd32), .irq(irq32));

  jump_button_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16), .HOLD_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .readdata(rd8), .irq(irq8));

  typedef struct {
    logic [31:0] e32;
    logic [31:0] e8;
    logic        chk_irq;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: a read issued before edge e is visible on readdata after edge e
  always @(negedge clk) begin
    exp_t e;
    if (rd_vld) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: readdata arrived with no expected entry");
      end else begin
        e = sb.pop_front();
        checks++;
        if (rd32 !== e.e32) begin
          errors++;
          $display("FAIL %s readdata(W32) got %h want %h", e.name, rd32, e.e32);
        end
        checks++;
        if (rd8 !== e.e8) begin
          errors++;
          $display("FAIL %s readdata(W8) got %h want %h", e.name, rd8, e.e8);
        end
        if (e.chk_irq) begin
          checks++;
          if (irq32 !== e.irq || irq8 !== e.irq) begin
            errors++;
            $display("FAIL %s irq got %b/%b want %b", e.name, irq32, irq8, e.irq);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e32, input logic [31:0] e8,
                    input logic ci, input logic iv, input string nm);
    exp_t e;
    e.e32 = e32; e.e8 = e8; e.chk_irq = ci; e.irq = iv; e.name = nm;
    sb.push_back(e);
    address = a; chipselect = 1'b1; write = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  // in_port high before edge k: bit1 (s2) visible from read 2, level from read 7 (edge k+6)
  task automatic press_timing(input string nm);
    logic [31:0] ex;
    in_port = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ex = ((j >= 2) ? 32'd2 : 32'd0) | ((j >= 7) ? 32'd1 : 32'd0);
      rd(2'd0, ex, ex, 1'b0, 1'b0, nm);
    end
  endtask

  task automatic release_btn();
    in_port = 1'b0;
    cyc(12);
    wr(2'd2, 32'd3);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_port = 1'b1; chipselect = 1'b0; write = 1'b0;
    address = 2'd0; writedata = 32'd0;
    cyc(2);
    rd(2'd0, 32'd0, 32'd0, 1'b1, 1'b0, "reset_state");
    reset = 1'b0;

    // 1: pin already high through reset
    press_timing("t1_press_latency");
    rd(2'd2, 32'd1, 32'd1, 1'b1, 1'b0, "t1_edgecap");
    wr(2'd2, 32'd3);
    release_btn();
    rd(2'd2, 32'd0, 32'd0, 1'b1, 1'b0, "t1_cleared");

    // 2: clean press, then unmask
    press_timing("t2_press_latency");
    rd(2'd2, 32'd1, 32'd1, 1'b1, 1'b0, "t2_edgecap_masked");
    wr(2'd1, 32'hFFFF_FFFD);
    rd(2'd1, 32'd1, 32'd1, 1'b1, 1'b1, "t2_irqmask_irq");
    wr(2'd2, 32'd3);
    rd(2'd2, 32'd0, 32'd0, 1'b1, 1'b0, "t2_w1c");
    release_btn();
    rd(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, "t2_released");

    // 3: 3-cycle glitch is rejected
    in_port = 1'b1; cyc(3); in_port = 1'b0; cyc(10);
    rd(2'd2, 32'd0, 32'd0, 1'b1, 1'b0, "t3_glitch_edgecap");
    rd(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, "t3_glitch_level");

    // 4: press at k, release starts r=k+101, bounce on r+3..r+4, accept at k+112 -> 105
    press_timing("t4_press_latency");
    cyc(93);
    in_port = 1'b0; cyc(3);
    in_port = 1'b1; cyc(2);
    in_port = 1'b0; cyc(12);
    rd(2'd2, 32'd3, 32'd3, 1'b1, 1'b1, "t4_edgecap");
    rd(2'd3, 32'd105, 32'd105, 1'b0, 1'b0, "t4_holdlast");
    wr(2'd2, 32'd3);

    // 5: W1C of bit0 on the edge the press is accepted
    wr(2'd1, 32'd3);
    in_port = 1'b1; cyc(6);
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd1, 32'd1, 1'b1, 1'b1, "t5_set_wins");
    wr(2'd2, 32'd3);
    rd(2'd2, 32'd0, 32'd0, 1'b1, 1'b0, "t5_clear");
    in_port = 1'b0; cyc(12);
    rd(2'd2, 32'd2, 32'd2, 1'b1, 1'b1, "t5_release_irq");
    wr(2'd2, 32'd3);

    // 6: 302-cycle hold -> 301 in 32 bits, saturates at 255 in 8 bits
    in_port = 1'b1; cyc(302);
    in_port = 1'b0; cyc(12);
    wr(2'd3, 32'h0000_00AA);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd3, 32'd301, 32'd255, 1'b0, 1'b0, "t6_holdlast_sat");
    rd(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, "t6_data_ro");
    rd(2'd2, 32'd3, 32'd3, 1'b1, 1'b1, "t6_edgecap");

    cyc(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
